// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_t;

    // Two-way round-robin choice: a lone requester always wins, a tie goes
    // to whichever side did not win the previous tie.
    function automatic arb_gnt_t rr_pick(input logic i_req, input logic d_req,
                                         input arb_gnt_t last);
        if (i_req && d_req) begin
            return (last == GNT_I) ? GNT_D : GNT_I;
        end else if (d_req) begin
            return GNT_D;
        end
        return GNT_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch + load/store) and memory-side signal bundle of the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned BW = XLEN / 8;

    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_rdata;
    logic            i_ack;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [BW-1:0]   d_be;
    logic [XLEN-1:0] d_rdata;
    logic            d_ack;
    logic            d_err;

    logic            m_req;
    logic            m_we;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [BW-1:0]   m_be;
    logic [XLEN-1:0] m_rdata;
    logic            m_ack;

    // Arbiter view: serves the core ports, drives the memory command.
    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_rdata, d_ack, d_err,
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_rdata, m_ack
    );

    // Environment view: core requesters plus the memory responder.
    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack, i_err,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_rdata, d_ack, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_rdata, m_ack
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; owns the record of which side won the last tie.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic [1:0] req,   // [0] = fetch, [1] = load/store
    input  logic     en,      // a grant is being taken this cycle
    output arb_gnt_t gnt
);

    arb_gnt_t last_gnt_q;
    arb_gnt_t last_gnt_d;

    // Winner for the current request pattern.
    always_comb begin
        gnt = rr_pick(req[0], req[1], last_gnt_q);
    end

    // Only a contested grant moves the round-robin pointer.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (en && req[0] && req[1]) begin
            last_gnt_d = gnt;
        end
    end

    // Pointer register; reset favours fetch on the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_gnt_q <= GNT_D;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports,
// one outstanding transaction, registered command/response, ack watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned BW = XLEN / 8;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_t      state_q, state_d;
    arb_gnt_t        owner_q, owner_d;
    arb_gnt_t        gnt;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [XLEN-1:0] m_addr_q, m_addr_d;
    logic [XLEN-1:0] m_wdata_q, m_wdata_d;
    logic [BW-1:0]   m_be_q, m_be_d;

    logic [XLEN-1:0] i_rdata_q, i_rdata_d;
    logic            i_err_q, i_err_d;
    logic            i_ack_q, i_ack_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            d_err_q, d_err_d;
    logic            d_ack_q, d_ack_d;

    logic            rsp_fire;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.d_req, bus.i_req}),
        .en    (state_q == ARB_IDLE),
        .gnt   (gnt)
    );

    // Next-state, command capture, watchdog and response steering.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        i_rdata_d = i_rdata_q;
        i_err_d   = i_err_q;
        i_ack_d   = 1'b0;
        d_rdata_d = d_rdata_q;
        d_err_d   = d_err_q;
        d_ack_d   = 1'b0;
        rsp_fire  = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (bus.i_req || bus.d_req) begin
                    owner_d = gnt;
                    m_req_d = 1'b1;
                    state_d = ARB_BUSY;
                    if (gnt == GNT_I) begin
                        m_we_d    = 1'b0;
                        m_addr_d  = bus.i_addr;
                        m_wdata_d = '0;
                        m_be_d    = '0;
                    end else begin
                        m_we_d    = bus.d_we;
                        m_addr_d  = bus.d_addr;
                        m_wdata_d = bus.d_wdata;
                        m_be_d    = bus.d_be;
                    end
                end
            end
            ARB_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.m_ack) begin
                    m_req_d  = 1'b0;
                    state_d  = ARB_RESP;
                    rsp_fire = 1'b1;
                    rsp_data = m_we_q ? '0 : bus.m_rdata;
                end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
                    m_req_d  = 1'b0;
                    state_d  = ARB_RESP;
                    rsp_fire = 1'b1;
                    rsp_err  = 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // Response registers are loaded on the BUSY->RESP edge, so the ack
        // pulse coincides with the single RESP cycle.
        if (rsp_fire) begin
            if (owner_q == GNT_I) begin
                i_rdata_d = rsp_data;
                i_err_d   = rsp_err;
                i_ack_d   = 1'b1;
            end else begin
                d_rdata_d = rsp_data;
                d_err_d   = rsp_err;
                d_ack_d   = 1'b1;
            end
        end
    end

    // State, command and response registers; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= GNT_I;
            cnt_q     <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            i_rdata_q <= '0;
            i_err_q   <= 1'b0;
            i_ack_q   <= 1'b0;
            d_rdata_q <= '0;
            d_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            i_rdata_q <= i_rdata_d;
            i_err_q   <= i_err_d;
            i_ack_q   <= i_ack_d;
            d_rdata_q <= d_rdata_d;
            d_err_q   <= d_err_d;
            d_ack_q   <= d_ack_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_be    = m_be_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_err   = i_err_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_ack   = d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus directed
// sequences, responses checked against a scoreboard queue.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned TO   = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_port_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        port;   // 0 = fetch, 1 = load/store
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] mdata;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    rsp_t sb_q[$];
    vec_t tbl[8];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    // Memory responder: waits for m_req, checks the command every cycle it
    // is held, acks after lat cycles with mdata.
    task automatic mem_serve(input string nm, input int lat, input logic [31:0] mdata,
                             input logic e_we, input logic [31:0] e_addr,
                             input logic [31:0] e_wdata, input logic [3:0] e_be);
        int w = 0;
        @(negedge clk);
        while (!bus.m_req && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!bus.m_req) begin
            n_checks++;
            $display("FAIL %s_m_req_wait: m_req still 0 after 20 cycles, required 1", nm);
            return;
        end
        for (int c = 0; c < lat; c++) begin
            chk1({nm, "_m_req"}, bus.m_req, 1'b1);
            chk1({nm, "_m_we"}, bus.m_we, e_we);
            chk({nm, "_m_addr"}, bus.m_addr, e_addr);
            chk({nm, "_m_wdata"}, bus.m_wdata, e_wdata);
            chk({nm, "_m_be"}, 32'(bus.m_be), 32'(e_be));
            if (c == lat - 1) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = mdata;
            end else begin
                bus.m_rdata = $urandom;
            end
            @(negedge clk);
        end
        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom;
        chk1({nm, "_m_req_drop"}, bus.m_req, 1'b0);
    endtask

    // Response monitor: every ack must match the oldest expectation.
    always @(negedge clk) begin : mon
        rsp_t e;
        if (bus.i_ack || bus.d_ack) begin
            chk1("single_ack", bus.i_ack & bus.d_ack, 1'b0);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_ack: got i_ack=%b d_ack=%b required none", bus.i_ack, bus.d_ack);
            end else begin
                e = sb_q.pop_front();
                chk1("ack_port", bus.d_ack, e.port);
                chk("ack_rdata", bus.d_ack ? bus.d_rdata : bus.i_rdata, e.rdata);
                chk1("ack_err", bus.d_ack ? bus.d_err : bus.i_err, e.err);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int c;
        int w;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.m_ack = 1'b0; bus.m_rdata = '0;

        //                is_d we  addr          wdata         be     lat mdata         e_we e_addr        e_wdata       e_be   e_rdata
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,   1, 32'h0050_0093, 1'b0, 32'h0000_0100, 32'h0,        4'h0,   32'h0050_0093};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 3, 32'h1234_5678, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_2004, 32'h0,        4'h0,   2, 32'hCAFE_F00D, 1'b0, 32'h0000_2004, 32'h0,        4'h0,   32'hCAFE_F00D};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0,   4, 32'h00A0_0113, 1'b0, 32'h0000_0104, 32'h0,        4'h0,   32'h00A0_0113};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_2008, 32'h0102_0304, 4'hF,   1, 32'hFFFF_FFFF, 1'b1, 32'h0000_2008, 32'h0102_0304, 4'hF,   32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_200C, 32'h0,        4'h0,   6, 32'h89AB_CDEF, 1'b0, 32'h0000_200C, 32'h0,        4'h0,   32'h89AB_CDEF};
        tbl[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0,   1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'h0,        4'h0,   32'hFFFF_FFFF};
        tbl[7] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,        4'h0,   2, 32'h0000_0013, 1'b0, 32'h0000_0108, 32'h0,        4'h0,   32'h0000_0013};

        // Reset held with both requests pending: nothing may leave the block.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0080;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("rst_m_req", bus.m_req, 1'b0);
            chk1("rst_i_ack", bus.i_ack, 1'b0);
            chk1("rst_d_ack", bus.d_ack, 1'b0);
        end
        chk("rst_m_addr", bus.m_addr, 32'h0);
        chk("rst_i_rdata", bus.i_rdata, 32'h0);
        reset = 1'b1;

        // First tie goes to fetch; the pending load follows.
        sb_q.push_back('{port: 1'b0, rdata: 32'h1111_1111, err: 1'b0});
        mem_serve("t1_i", 1, 32'h1111_1111, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
        bus.i_req = 1'b0;
        sb_q.push_back('{port: 1'b1, rdata: 32'h2222_2222, err: 1'b0});
        mem_serve("t1_d", 2, 32'h2222_2222, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        bus.d_req = 1'b0;
        @(negedge clk);

        // Single-requester vectors; fetch vectors present junk on the idle data port.
        for (int k = 0; k < 8; k++) begin
            if (tbl[k].is_d) begin
                bus.d_req = 1'b1; bus.d_we = tbl[k].we; bus.d_addr = tbl[k].addr;
                bus.d_wdata = tbl[k].wdata; bus.d_be = tbl[k].be;
                bus.i_addr = 32'hBAD0_0000;
            end else begin
                bus.i_req = 1'b1; bus.i_addr = tbl[k].addr;
                bus.d_we = 1'b1; bus.d_addr = 32'hBADB_AD00; bus.d_wdata = 32'hBAD0_BAD0; bus.d_be = 4'hF;
            end
            sb_q.push_back('{port: tbl[k].is_d, rdata: tbl[k].exp_rdata, err: 1'b0});
            mem_serve($sformatf("v%0d", k), tbl[k].lat, tbl[k].mdata, tbl[k].exp_we,
                      tbl[k].exp_addr, tbl[k].exp_wdata, tbl[k].exp_be);
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            @(negedge clk);
        end
        chk("hold_i_rdata", bus.i_rdata, 32'h0000_0013);
        chk("hold_d_rdata", bus.d_rdata, 32'h89AB_CDEF);

        // Both held for four transactions: grants must alternate D,I,D,I.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0200;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_3000; bus.d_wdata = '0; bus.d_be = '0;
        for (int j = 0; j < 4; j++) begin
            sb_q.push_back('{port: (j % 2 == 0), rdata: 32'hA000_0000 + 32'(j), err: 1'b0});
            mem_serve($sformatf("rr%0d", j), j + 1, 32'hA000_0000 + 32'(j), 1'b0,
                      (j % 2 == 0) ? 32'h0000_3000 : 32'h0000_0200, 32'h0, 4'h0);
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("rr_i_rdata_hold", bus.i_rdata, 32'hA000_0003);
        chk("rr_d_rdata_hold", bus.d_rdata, 32'hA000_0002);

        // Memory never acks: watchdog ends the load after TO busy cycles.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_4000;
        sb_q.push_back('{port: 1'b1, rdata: 32'h0, err: 1'b1});
        w = 0;
        @(negedge clk);
        while (!bus.m_req && w < 20) begin w++; @(negedge clk); end
        c = 0;
        while (bus.m_req && c < 40) begin
            chk("to_m_addr", bus.m_addr, 32'h0000_4000);
            c++;
            @(negedge clk);
        end
        chk("to_busy_cycles", 32'(c), 32'(TO));
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        chk1("to_d_err_hold", bus.d_err, 1'b1);
        chk("to_d_rdata_hold", bus.d_rdata, 32'h0);
        chk1("to_d_ack_low", bus.d_ack, 1'b0);
        chk1("to_m_req_low", bus.m_req, 1'b0);

        // Reset during BUSY: transaction abandoned, no ack, fresh request completes.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0500;
        w = 0;
        @(negedge clk);
        while (!bus.m_req && w < 20) begin w++; @(negedge clk); end
        chk1("rb_m_req_busy", bus.m_req, 1'b1);
        reset = 1'b0;
        bus.i_req = 1'b0;
        @(negedge clk);
        chk1("rb_m_req", bus.m_req, 1'b0);
        chk1("rb_i_ack", bus.i_ack, 1'b0);
        chk1("rb_d_ack", bus.d_ack, 1'b0);
        chk("rb_i_rdata", bus.i_rdata, 32'h0);
        chk1("rb_d_err", bus.d_err, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_6000;
        sb_q.push_back('{port: 1'b1, rdata: 32'h5A5A_5A5A, err: 1'b0});
        mem_serve("rb_fresh", 1, 32'h5A5A_5A5A, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        bus.d_req = 1'b0;
        repeat (3) @(negedge clk);

        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d responses outstanding, required 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
